ddr_rd_arb: RTL and testbench
=============================

// Module: ddr_rd_arb
// PURPOSE
//  - N-channel read-only DDR service: arbitrates toggle-style read requests from NUM_CH clients onto one
//    Avalon-MM burst master (DDR3 bridge port) and returns each beat to the requesting channel.
//  - Parametrised successor of the two-channel 64-bit read service: NUM_CH/data/address/burst widths,
//    waitrequest-correct command hold, async reset, last-beat flag, optional round-robin.
// PARAMETERS
//  NUM_CH   2   number of client channels (1..8)
//  DATA_W   64  Avalon data width; byteenable width = DATA_W/8
//  ADDR_W   29  word address width (byte address bits [ADDR_W+2:3] for DATA_W=64)
//  BURST_W  8   burst count width
// PORTS
//  clk             in   1               system clock; all logic rising-edge
//  reset           in   1               asynchronous, active-high reset
//  ram_waitrequest in   1               Avalon waitrequest
//  ram_burstcnt    out  BURST_W         Avalon burstcount
//  ram_addr        out  ADDR_W          Avalon word address
//  ram_readdata    in   DATA_W          Avalon read data
//  ram_read_ready  in   1               Avalon readdatavalid
//  ram_read        out  1               Avalon read command
//  ram_write       out  1               tied 0
//  ram_writedata   out  DATA_W          tied 0
//  ram_byteenable  out  DATA_W/8        tied all-ones
//  ram_bcnt        out  BURST_W         beats received in current burst
//  busy            out  1               high while not IDLE
//  ch_addr         in   NUM_CH*ADDR_W   per-channel word address, channel i at [i*ADDR_W +: ADDR_W]
//  ch_burst        in   NUM_CH*BURST_W  per-channel burst length
//  ch_req          in   NUM_CH          toggle request: pending while ch_req[i] != ack[i]
//  ch_data         out  NUM_CH*DATA_W   per-channel registered beat data (holds last beat)
//  ch_ready        out  NUM_CH          1-cycle pulse per delivered beat
//  ch_last         out  NUM_CH          1-cycle pulse coincident with ch_ready on final beat
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, ack=0, ram_read=0, ram_addr=0, ram_burstcnt=0, ram_bcnt=0,
//    busy=0, ch_data=0, ch_ready=0, ch_last=0, RR pointer=NUM_CH-1. Mid-burst reset abandons burst;
//    late readdatavalid beats after release are ignored (IDLE ignores ram_read_ready).
//  - ch_req high at reset release with ack=0 is a pending request (toggle semantics).
//  - FSM IDLE: on edge with >=1 pending channel: grant g, ack[g]<=ch_req[g], latch addr/burst of g,
//    ram_read<=1, ram_bcnt<=0 -> ISSUE. Toggle at edge N sampled at N+1; ram_read high after N+1.
//  - ISSUE: ram_read/addr/burstcnt held stable; on edge with ram_waitrequest=0: ram_read<=0 -> DATA.
//  - DATA: each edge with ram_read_ready=1: ch_data[g]<=ram_readdata, ch_ready[g]<=1, ram_bcnt+=1;
//    if ram_bcnt==ram_burstcnt-1 also ch_last[g]<=1, -> IDLE. ram_read_ready ignored outside DATA.
//  - Beat-to-client latency 1 cycle; other channels' ch_data untouched. ch_ready/ch_last default 0.
//  - Burst 0 on ch_burst is issued as 1 (Avalon forbids 0). Max burst 2^BURST_W-1, ram_bcnt no wrap.
//  - Re-toggle of the channel being served: pending again, served after current burst completes.
//    Two toggles between grants cancel (one request lost by protocol, not an error).
//  - Simultaneous pending requests: one grant per IDLE visit; min 1 idle cycle between bursts.
//  - ram_write=0, ram_writedata=0, ram_byteenable=all-ones constant, also during reset.
// CONFIGURATION
//  DDR_RD_ARB_RR_EN defined: round-robin; search starts at (last grant+1) mod NUM_CH, pointer updated on
//    grant. Undefined: fixed priority, lowest index wins (starvation of high indices possible).
// TESTING
//  1 NUM_CH=2, toggle ch_req[0], addr 0x100, burst 4, waitrequest 0 -> ram_read 1 cycle, addr 0x100,
//    burstcnt 4; 4 ch_ready[0] pulses, ch_last[0] on 4th, ch_data[0]=4th beat, ch_ready[1] stays 0.
//  2 waitrequest held 3 cycles in ISSUE -> ram_read/addr/burstcnt stable 4 cycles, single command.
//  3 ch_req[0],ch_req[1] toggle same edge, NUM_CH=4, RR_EN -> grants 0 then 1; without RR_EN with ch0
//    re-toggled after each burst -> ch1 never granted in 3 bursts.
//  4 ch_burst=0 -> ram_burstcnt=1, one beat, ch_ready and ch_last pulse together.
//  5 reset asserted after 2 of 8 beats -> all outputs at reset values same cycle; stray readdatavalid
//    after release produces no ch_ready; new toggle served normally.
//  6 readdatavalid gaps (beat, 2 idle, beat) burst 2 -> ram_bcnt 0->1->2, return to IDLE, busy drops.

Source files
------------

// File: rtl/ddr_rd_arb_if.sv
// Signal bundle for ddr_rd_arb: Avalon-MM burst read master plus the per-channel
// toggle-request client ports. The arbiter uses the master modport, its environment the slave one.
interface ddr_rd_arb_if #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 29,
  parameter int BURST_W = 8
);
  logic                      ram_waitrequest;
  logic [BURST_W-1:0]        ram_burstcnt;
  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_readdata;
  logic                      ram_read_ready;
  logic                      ram_read;
  logic                      ram_write;
  logic [DATA_W-1:0]         ram_writedata;
  logic [DATA_W/8-1:0]       ram_byteenable;
  logic [BURST_W-1:0]        ram_bcnt;
  logic                      busy;
  logic [NUM_CH*ADDR_W-1:0]  ch_addr;
  logic [NUM_CH*BURST_W-1:0] ch_burst;
  logic [NUM_CH-1:0]         ch_req;
  logic [NUM_CH*DATA_W-1:0]  ch_data;
  logic [NUM_CH-1:0]         ch_ready;
  logic [NUM_CH-1:0]         ch_last;

  modport master (
    input  ram_waitrequest, ram_readdata, ram_read_ready,
    input  ch_addr, ch_burst, ch_req,
    output ram_burstcnt, ram_addr, ram_read, ram_write, ram_writedata, ram_byteenable,
    output ram_bcnt, busy, ch_data, ch_ready, ch_last
  );

  modport slave (
    output ram_waitrequest, ram_readdata, ram_read_ready,
    output ch_addr, ch_burst, ch_req,
    input  ram_burstcnt, ram_addr, ram_read, ram_write, ram_writedata, ram_byteenable,
    input  ram_bcnt, busy, ch_data, ch_ready, ch_last
  );
endinterface

// File: rtl/ddr_rd_arb.sv
// N-channel read-only DDR arbiter: toggle requests in, Avalon-MM bursts out, beats routed back.
// Define DDR_RD_ARB_RR_EN for round-robin grants; otherwise fixed priority (lowest index wins).
module ddr_rd_arb #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 29,
  parameter int BURST_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  ddr_rd_arb_if.master  bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DATA
  } state_t;

  state_t                    r_state;
  state_t                    w_nextState;

  logic [NUM_CH-1:0]         r_ack;
  logic [CH_W-1:0]           r_grant;
  logic                      r_read;
  logic [ADDR_W-1:0]         r_addr;
  logic [BURST_W-1:0]        r_burstcnt;
  logic [BURST_W-1:0]        r_bcnt;
  logic [NUM_CH*DATA_W-1:0]  r_chData;
  logic [NUM_CH-1:0]         r_chReady;
  logic [NUM_CH-1:0]         r_chLast;

  logic [NUM_CH-1:0]         w_pending;
  logic                      w_anyPending;
  logic                      w_found;
  logic [CH_W-1:0]           w_grantIdx;
  logic [ADDR_W-1:0]         w_selAddr;
  logic [BURST_W-1:0]        w_selBurst;
  logic                      w_grantEn;
  logic                      w_accept;
  logic                      w_beat;
  logic                      w_lastBeat;

`ifdef DDR_RD_ARB_RR_EN
  logic [CH_W-1:0]           r_rrPtr;
  logic [CH_W-1:0]           w_candIdx;
`endif

  // A channel is pending while its request toggle differs from our acknowledge copy.
  assign w_pending    = bus.ch_req ^ r_ack;
  assign w_anyPending = |w_pending;

  always_comb begin : arbSelect
    w_found    = 1'b0;
    w_grantIdx = '0;
`ifdef DDR_RD_ARB_RR_EN
    w_candIdx  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_candIdx = CH_W'((int'(r_rrPtr) + 1 + k) % NUM_CH);
      if (!w_found && w_pending[w_candIdx]) begin
        w_found    = 1'b1;
        w_grantIdx = w_candIdx;
      end
    end
`else
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_found && w_pending[k]) begin
        w_found    = 1'b1;
        w_grantIdx = CH_W'(k);
      end
    end
`endif
  end

  always_comb begin : chanMux
    w_selAddr  = '0;
    w_selBurst = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_grantIdx == CH_W'(k)) begin
        w_selAddr  = bus.ch_addr[k*ADDR_W +: ADDR_W];
        w_selBurst = bus.ch_burst[k*BURST_W +: BURST_W];
      end
    end
  end

  always_comb begin : fsmNext
    w_nextState = r_state;
    w_grantEn   = 1'b0;
    w_accept    = 1'b0;
    w_beat      = 1'b0;
    w_lastBeat  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_anyPending && w_found) begin
          w_grantEn   = 1'b1;
          w_nextState = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!bus.ram_waitrequest) begin
          w_accept    = 1'b1;
          w_nextState = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.ram_read_ready) begin
          w_beat = 1'b1;
          if (r_bcnt == r_burstcnt - BURST_W'(1)) begin
            w_lastBeat  = 1'b1;
            w_nextState = ST_IDLE;
          end
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin : stateReg
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Avalon forbids a zero burstcount, so a client asking for 0 beats gets one.
  always_ff @(posedge clk or posedge reset) begin : cmdPath
    if (reset) begin
      r_ack      <= '0;
      r_grant    <= '0;
      r_read     <= 1'b0;
      r_addr     <= '0;
      r_burstcnt <= '0;
      r_bcnt     <= '0;
    end else begin
      if (w_grantEn) begin
        r_ack[w_grantIdx] <= bus.ch_req[w_grantIdx];
        r_grant           <= w_grantIdx;
        r_addr            <= w_selAddr;
        r_burstcnt        <= (w_selBurst == '0) ? BURST_W'(1) : w_selBurst;
        r_read            <= 1'b1;
        r_bcnt            <= '0;
      end
      if (w_accept) begin
        r_read <= 1'b0;
      end
      if (w_beat) begin
        r_bcnt <= r_bcnt + BURST_W'(1);
      end
    end
  end

`ifdef DDR_RD_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin : rrPointer
    if (reset) begin
      r_rrPtr <= CH_W'(NUM_CH - 1);
    end else if (w_grantEn) begin
      r_rrPtr <= w_grantIdx;
    end
  end
`endif

  // Only the granted channel's data register moves; the others keep their last beat.
  always_ff @(posedge clk or posedge reset) begin : clientPath
    if (reset) begin
      r_chData  <= '0;
      r_chReady <= '0;
      r_chLast  <= '0;
    end else begin
      r_chReady <= '0;
      r_chLast  <= '0;
      if (w_beat) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (r_grant == CH_W'(k)) begin
            r_chData[k*DATA_W +: DATA_W] <= bus.ram_readdata;
            r_chReady[k]                 <= 1'b1;
            r_chLast[k]                  <= w_lastBeat;
          end
        end
      end
    end
  end

  assign bus.ram_read       = r_read;
  assign bus.ram_addr       = r_addr;
  assign bus.ram_burstcnt   = r_burstcnt;
  assign bus.ram_bcnt       = r_bcnt;
  assign bus.ram_write      = 1'b0;
  assign bus.ram_writedata  = '0;
  assign bus.ram_byteenable = '1;
  assign bus.busy           = (r_state != ST_IDLE);
  assign bus.ch_data        = r_chData;
  assign bus.ch_ready       = r_chReady;
  assign bus.ch_last        = r_chLast;

  // The command must not move while the slave stalls it.
  assert property (@(posedge clk) disable iff (reset)
    (r_read && bus.ram_waitrequest) |=> (r_read && $stable(r_addr) && $stable(r_burstcnt)));

  assert property (@(posedge clk) disable iff (reset) $onehot0(r_chReady));

  assert property (@(posedge clk) disable iff (reset) ((r_chLast & ~r_chReady) == '0));

endmodule

// File: tb/tb_ddr_rd_arb.sv
// Randomised self-checking bench for ddr_rd_arb: acts as DDR slave and as the clients,
// predicting grants, commands and returned beats from a transaction-level model.
`timescale 1ns/1ps
module tb_ddr_rd_arb;
  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 29;
  localparam int BURST_W  = 8;
  localparam int TOTAL_DW = NUM_CH * DATA_W;

  logic clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   errorCount = 0;

  logic [NUM_CH-1:0]  reqBits;
  logic [NUM_CH-1:0]  modelAck;
  logic [ADDR_W-1:0]  chAddr    [NUM_CH];
  logic [BURST_W-1:0] chBurst   [NUM_CH];
  logic [DATA_W-1:0]  modelData [NUM_CH];
  int                 rrPtr;
  int                 forceRetoggleCh0 = 0;
  int                 togglePct = 0;

  ddr_rd_arb_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

  ddr_rd_arb #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [TOTAL_DW-1:0] actual,
                             input logic [TOTAL_DW-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rdValid, input logic [DATA_W-1:0] rdData,
                               input logic waitReq);
    bus.ram_read_ready  = rdValid;
    bus.ram_readdata    = rdData;
    bus.ram_waitrequest = waitReq;
  endtask

  task automatic pushClient();
    for (int c = 0; c < NUM_CH; c++) begin
      bus.ch_addr[c*ADDR_W +: ADDR_W]    = chAddr[c];
      bus.ch_burst[c*BURST_W +: BURST_W] = chBurst[c];
    end
    bus.ch_req = reqBits;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TOTAL_DW-1:0] packData();
    logic [TOTAL_DW-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c*DATA_W +: DATA_W] = modelData[c];
    return v;
  endfunction

  // Rotating search from the slot after the last winner, or from 0 for fixed priority.
  function automatic int predictGrant(input logic [NUM_CH-1:0] pend);
    int start;
    start = 0;
`ifdef DDR_RD_ARB_RR_EN
    start = (rrPtr + 1) % NUM_CH;
`endif
    for (int k = 0; k < NUM_CH; k++) begin
      if (pend[(start + k) % NUM_CH]) return (start + k) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_read"},   bus.ram_read, 0);
    checkOutput({tag, "_busy"},   bus.busy, 0);
    checkOutput({tag, "_addr"},   bus.ram_addr, 0);
    checkOutput({tag, "_burst"},  bus.ram_burstcnt, 0);
    checkOutput({tag, "_bcnt"},   bus.ram_bcnt, 0);
    checkOutput({tag, "_data"},   bus.ch_data, 0);
    checkOutput({tag, "_ready"},  bus.ch_ready, 0);
    checkOutput({tag, "_last"},   bus.ch_last, 0);
    checkOutput({tag, "_write"},  bus.ram_write, 0);
    checkOutput({tag, "_wdata"},  bus.ram_writedata, 0);
    checkOutput({tag, "_byteEn"}, bus.ram_byteenable, {(DATA_W/8){1'b1}});
  endtask

  task automatic grantAndServe();
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] oneHot;
    logic [DATA_W-1:0] beatData;
    int g, n, waits, gaps, c;
    pend = reqBits ^ modelAck;
    g = predictGrant(pend);
    applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    tick();
    modelAck[g] = reqBits[g];
    rrPtr       = g;
    oneHot      = '0;
    oneHot[g]   = 1'b1;
    n = (chBurst[g] == 0) ? 1 : int'(chBurst[g]);
    checkOutput("cmdRead",  bus.ram_read, 1);
    checkOutput("cmdBusy",  bus.busy, 1);
    checkOutput("cmdAddr",  bus.ram_addr, chAddr[g]);
    checkOutput("cmdBurst", bus.ram_burstcnt, n);
    checkOutput("cmdBcnt",  bus.ram_bcnt, 0);
    checkOutput("idleReadyIgnored", bus.ch_ready, 0);
    waits = $urandom_range(0, 3);
    for (int w = 0; w < waits; w++) begin
      applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b1);
      tick();
      checkOutput("holdRead",  bus.ram_read, 1);
      checkOutput("holdAddr",  bus.ram_addr, chAddr[g]);
      checkOutput("holdBurst", bus.ram_burstcnt, n);
      checkOutput("issueReadyIgnored", bus.ch_ready, 0);
    end
    applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b0);
    tick();
    checkOutput("readDropped", bus.ram_read, 0);
    checkOutput("acceptReadyIgnored", bus.ch_ready, 0);
    for (int b = 0; b < n; b++) begin
      gaps = (n > 16) ? 0 : $urandom_range(0, 2);
      for (int q = 0; q < gaps; q++) begin
        applyStimulus(1'b0, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        tick();
        checkOutput("gapNoReady", bus.ch_ready, 0);
        checkOutput("gapBcnt", bus.ram_bcnt, b);
      end
      if (g == 0 && forceRetoggleCh0 > 0 && b == 0) begin
        reqBits[0] = ~reqBits[0];
        forceRetoggleCh0--;
        pushClient();
      end else if (int'($urandom_range(0, 99)) < togglePct) begin
        c = $urandom_range(0, NUM_CH - 1);
        reqBits[c] = ~reqBits[c];
        chAddr[c]  = ADDR_W'($urandom);
        chBurst[c] = BURST_W'($urandom_range(0, 5));
        pushClient();
      end
      beatData = {$urandom, $urandom};
      applyStimulus(1'b1, beatData, 1'($urandom_range(0, 1)));
      tick();
      modelData[g] = beatData;
      checkOutput("beatReady", bus.ch_ready, oneHot);
      checkOutput("beatLast",  bus.ch_last, (b == n - 1) ? oneHot : '0);
      checkOutput("beatData",  bus.ch_data, packData());
      checkOutput("beatBcnt",  bus.ram_bcnt, b + 1);
      checkOutput("beatBusy",  bus.busy, (b != n - 1));
      checkOutput("dataRead",  bus.ram_read, 0);
    end
    applyStimulus(1'b0, '0, 1'b0);
  endtask

  task automatic runPending();
    int guard;
    guard = 0;
    while ((reqBits ^ modelAck) != '0 && guard < 200) begin
      grantAndServe();
      guard++;
    end
    applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b0);
    tick();
    checkOutput("idleNoRead",  bus.ram_read, 0);
    checkOutput("idleBusy",    bus.busy, 0);
    checkOutput("idleNoReady", bus.ch_ready, 0);
    applyStimulus(1'b0, '0, 1'b0);
  endtask

  task automatic resetMidBurst();
    logic [DATA_W-1:0] beatData;
    int g;
    chBurst[0] = 8;
    reqBits[0] = ~reqBits[0];
    pushClient();
    g = predictGrant(reqBits ^ modelAck);
    applyStimulus(1'b0, '0, 1'b0);
    tick();
    modelAck[g] = reqBits[g];
    rrPtr = g;
    tick();
    for (int b = 0; b < 2; b++) begin
      beatData = {$urandom, $urandom};
      applyStimulus(1'b1, beatData, 1'b0);
      tick();
      modelData[g] = beatData;
    end
    checkOutput("preResetBcnt", bus.ram_bcnt, 2);
    checkOutput("preResetData", bus.ch_data, packData());
    reset = 1'b1;
    #1;
    checkResetValues("midReset");
    modelAck = '0;
    rrPtr    = NUM_CH - 1;
    for (int c = 0; c < NUM_CH; c++) modelData[c] = '0;
    reqBits = '0;
    pushClient();
    applyStimulus(1'b1, {$urandom, $urandom}, 1'b0);
    tick();
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b1, {$urandom, $urandom}, 1'b0);
      tick();
      checkOutput("strayNoReady", bus.ch_ready, 0);
      checkOutput("strayBusy",    bus.busy, 0);
      checkOutput("strayData",    bus.ch_data, 0);
    end
    applyStimulus(1'b0, '0, 1'b0);
    reqBits[0] = ~reqBits[0];
    chBurst[0] = 3;
    pushClient();
    runPending();
  endtask

  initial begin
    int mask;
    reset    = 1'b1;
    reqBits  = '0;
    modelAck = '0;
    rrPtr    = NUM_CH - 1;
    for (int c = 0; c < NUM_CH; c++) begin
      chAddr[c]    = ADDR_W'(32'h1000 * (c + 1));
      chBurst[c]   = 2;
      modelData[c] = '0;
    end
    applyStimulus(1'b0, '0, 1'b0);
    pushClient();
    repeat (3) tick();
    checkResetValues("reset");

    $display("[TB] request held high across reset release");
    reqBits[1] = 1'b1;
    pushClient();
    tick();
    reset = 1'b0;
    runPending();

    $display("[TB] single burst of 4 at 0x100");
    chAddr[0]  = 29'h100;
    chBurst[0] = 4;
    reqBits[0] = ~reqBits[0];
    pushClient();
    runPending();

    $display("[TB] simultaneous ch0/ch1 with ch0 re-toggled");
    chBurst[0] = 2;
    chBurst[1] = 3;
    forceRetoggleCh0 = 2;
    reqBits[0] = ~reqBits[0];
    reqBits[1] = ~reqBits[1];
    pushClient();
    runPending();
    forceRetoggleCh0 = 0;

    $display("[TB] zero and maximum burst lengths");
    chBurst[2] = 0;
    chBurst[3] = 8'hFF;
    reqBits[2] = ~reqBits[2];
    reqBits[3] = ~reqBits[3];
    pushClient();
    runPending();

    $display("[TB] reset in the middle of a burst");
    resetMidBurst();

    $display("[TB] randomised rounds");
    togglePct = 15;
    for (int r = 0; r < 40; r++) begin
      mask = $urandom_range(1, (1 << NUM_CH) - 1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (mask[c]) begin
          reqBits[c] = ~reqBits[c];
          chAddr[c]  = ADDR_W'($urandom);
          chBurst[c] = BURST_W'($urandom_range(0, 6));
        end
      end
      pushClient();
      runPending();
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  initial begin
    #500000;
    errorCount++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
